// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: producer/consumer handshake, status and RAM port bundle for fifo_ctrl
interface fifo_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              flush;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   level;
    logic              afull;
    logic              ovf;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_raddr;
    logic              ram_rd;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output flush, wr_valid, wr_data, rd_ready, ram_rdata,
        input  wr_ready, rd_valid, rd_data, level, afull, ovf,
               ram_wdata, ram_waddr, ram_wr, ram_raddr, ram_rd
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready, ram_rdata,
        output wr_ready, rd_valid, rd_data, level, afull, ovf,
               ram_wdata, ram_waddr, ram_wr, ram_raddr, ram_rd
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO controller around an external 1-cycle-read dual-port RAM with one-word prefetch
module fifo_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int AFULL_LVL = 2**ADDR_W-4
) (
    input logic        clk,
    input logic        rst_n,
    fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              w_full;
    logic              w_wr_ready;
    logic              w_wr_en;
    logic              w_fetch;
    logic [ADDR_W:0]   w_level;

    // handshake decode; wr_ready is held low during reset so nothing is accepted
    always_comb begin
        w_full     = (r_cnt == DEPTH);
        w_wr_ready = rst_n && !w_full && !bus.flush;
        w_wr_en    = bus.wr_valid && w_wr_ready;
        w_fetch    = (r_cnt != '0) && (!r_rd_valid || bus.rd_ready) && !bus.flush;
        w_level    = r_cnt + {{ADDR_W{1'b0}}, r_rd_valid};
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.ram_wr    = w_wr_en;
    assign bus.ram_waddr = r_wptr;
    assign bus.ram_wdata = DATA_W'(bus.wr_data);
    assign bus.ram_rd    = w_fetch;
    assign bus.ram_raddr = r_rptr;
    assign bus.rd_data   = DATA_W'(bus.ram_rdata);
    assign bus.rd_valid  = r_rd_valid;
    assign bus.level     = w_level;
    assign bus.afull     = 32'(w_level) >= 32'(AFULL_LVL);
    assign bus.ovf       = r_ovf;

    // pointers, RAM word count, prefetched-word flag and sticky overflow; flush clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (bus.flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_wptr     <= r_wptr + ADDR_W'(w_wr_en);
            r_rptr     <= r_rptr + ADDR_W'(w_fetch);
            r_cnt      <= r_cnt + (ADDR_W+1)'(w_wr_en) - (ADDR_W+1)'(w_fetch);
            r_rd_valid <= w_fetch || (r_rd_valid && !bus.rd_ready);
            r_ovf      <= r_ovf || (bus.wr_valid && w_full);
        end
    end
endmodule
